csr_cmd_sequencer: RTL
======================

Name: csr_cmd_sequencer

Overview:
- Register-bus initiator that drives the CGRA's DMA/config CSR block from a queue of commands.
- Each command is a write, a read, or a poll-until-match. Completions are returned through a response handshake.
- Sits between a host-side or test-harness command source and the reg_req/reg_rsp interface of the CSR responder.
- Use: autonomous "load config → start → wait done" sequences without per-access software involvement.

Parameters:
- CMD_FIFO_DEPTH, 4, command FIFO entries; power of 2, ≥2.
- POLL_GAP, 4, idle cycles between successive poll reads; ≥1.
- POLL_TIMEOUT, 1024, maximum poll reads before a TIMEOUT response; ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command FIFO not full
- cmd_op_i  in  2  00 WRITE, 01 READ, 10 POLL, 11 illegal
- cmd_addr_i  in  32  CSR byte address
- cmd_data_i  in  32  write data; for POLL, the expected value
- cmd_mask_i  in  32  POLL compare mask; ignored otherwise
- flush_i  in  1  synchronous clear of queued (not in-flight) commands
- reg_valid_o  out  1  bus request valid
- reg_write_o  out  1  1 = write
- reg_addr_o  out  32  bus address
- reg_wdata_o  out  32  bus write data
- reg_wstrb_o  out  4  F for write, 0 for read
- reg_ready_i  in  1  responder accepts/completes
- reg_rdata_i  in  32  read data
- reg_error_i  in  1  responder error
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  32  read/poll data; 0 for WRITE
- rsp_status_o  out  2  00 OK, 01 BUS_ERR, 10 TIMEOUT, 11 ILLEGAL
- busy_o  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset: every output 0 except cmd_ready_o=1. FIFO empty, FSM IDLE, counters 0.
- Reset mid-transaction: reg_valid_o and rsp_valid_o drop asynchronously, queued commands are lost, and the in-flight request is abandoned.
- FIFO:
  - cmd_ready_o = !full. Push on cmd_valid_i & cmd_ready_o.
  - When full there is no push in the same cycle as a pop; ready rises the cycle after the pop.
  - flush_i empties the FIFO next cycle and blocks pushes in that cycle. The current FSM command completes normally, including its response.
- FSM states IDLE, REQ, GAP, RESP:
  - IDLE: FIFO non-empty → pop into working registers (op, addr, data, mask), poll_cnt=0, go to REQ. Exception: op=11 goes to RESP with ILLEGAL and data 0, with no bus access.
  - REQ: reg_valid_o=1. addr/wdata/write/wstrb are held stable until the reg_ready_i sample. reg_write_o=(op==WRITE). reg_wdata_o=data for WRITE, 0 otherwise.
  - REQ + reg_ready_i, in priority order:
    - reg_error_i → RESP, BUS_ERR, rsp_data=reg_rdata_i.
    - WRITE → RESP OK, data 0.
    - READ → RESP OK, data reg_rdata_i.
    - POLL with (reg_rdata_i & mask)==(data & mask) → RESP OK, data reg_rdata_i.
    - Otherwise poll_cnt++. If the new poll_cnt==POLL_TIMEOUT → RESP TIMEOUT, data = last rdata. Else → GAP with gap_cnt=POLL_GAP-1.
  - GAP: reg_valid_o=0. gap_cnt==0 → REQ, else decrement.
  - RESP: rsp_valid_o=1, with data/status stable until rsp_ready_i. On rsp_ready_i → IDLE. A new command is popped no earlier than the next cycle.
- Latency: cmd handshake in cycle 0 → FIFO pop cycle 1 → reg_valid_o cycle 2. With reg_ready_i=1, rsp_valid_o is in cycle 3. Back-to-back command issue interval is 3 cycles when rsp_ready_i=1.
- Poll counter width: $clog2(POLL_TIMEOUT+1); no wrap.
- Commands are processed strictly in order; one outstanding bus request max.

Optional Feature:
- Macro CSR_SEQ_POLL_TIMEOUT_EN.
- Defined: poll_cnt and the TIMEOUT response exist as specified above.
- Undefined: POLL retries indefinitely until match or bus error, status 10 is never produced, and the poll counter is not instantiated (POLL_TIMEOUT is ignored).

Test Plan:
- WRITE addr 0x04 data 0x8000_1000, reg_ready_i=1 → reg_valid_o in cycle 2 with write=1, wstrb=F; rsp in cycle 3 status 00, data 0.
- WRITE 0xF0=5, WRITE 0xF4=7, READ 0xF8, responder returns 12 → three responses in order, the last status 00 data 0x0000_000C.
- POLL 0x00 mask 0x2 data 0x2; responder returns 0,0,0,2 → exactly 4 bus reads, each separated by POLL_GAP=4 idle cycles; rsp status 00 data 2.
- POLL never matching, POLL_TIMEOUT=8, macro defined → 8 reads, then status 10. With macro undefined: reads continue past 8 and no response is issued.
- reg_ready_i held low 5 cycles during a WRITE → reg_addr/wdata stable all 6 cycles, a single completion, then a response. reg_error_i=1 on a READ → status 01.
- Push 5 commands with rsp_ready_i=0 and depth 4 → cmd_ready_o=0 after the FIFO fills. Assert flush_i → busy_o stays 1 until the held response is taken, then 0, with no further bus traffic. op=11 → status 11 and reg_valid_o never asserted.

Source files
------------

// File: rtl/csr_cmd_sequencer.sv
// CSR command sequencer: queues WRITE/READ/POLL commands and replays them on a reg_req/reg_rsp bus.
// Optional feature macro CSR_SEQ_POLL_TIMEOUT_EN bounds POLL retries and enables the TIMEOUT status.
module csr_cmd_sequencer #(
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int POLL_GAP       = 4,
  parameter int POLL_TIMEOUT   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  input  logic [31:0] cmd_mask_i,
  input  logic        flush_i,
  output logic        reg_valid_o,
  output logic        reg_write_o,
  output logic [31:0] reg_addr_o,
  output logic [31:0] reg_wdata_o,
  output logic [3:0]  reg_wstrb_o,
  input  logic        reg_ready_i,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_error_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [1:0]  rsp_status_o,
  output logic        busy_o
);

  localparam int AW = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [AW:0] FULL_CNT = CMD_FIFO_DEPTH[AW:0];

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUS_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ILL     = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, GAP, RESP} state_t;

  state_t state_q, state_d;

  cmd_t          fifo_mem [CMD_FIFO_DEPTH];
  cmd_t          cmd_in, head, cur;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic [31:0]   rsp_data;
  logic [1:0]    rsp_status;
  logic [GW-1:0] gap_cnt;
  logic          is_write, is_poll, poll_match, req_done, poll_expired;

  // ---------------- command FIFO ----------------
  assign cmd_in      = {cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i};
  assign head        = fifo_mem[rd_ptr];
  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign cmd_ready_o = ~full;
  // A flush cycle drops any offered command and never feeds the FSM.
  assign push        = cmd_valid_i & ~full & ~flush_i;
  assign pop         = (state_q == IDLE) & ~empty & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  // ---------------- completion decode ----------------
  assign is_write   = (cur.op == OP_WRITE);
  assign is_poll    = (cur.op == OP_POLL);
  assign poll_match = ((reg_rdata_i ^ cur.data) & cur.mask) == '0;
  assign req_done   = reg_error_i | ~is_poll | poll_match;

`ifdef CSR_SEQ_POLL_TIMEOUT_EN
  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  logic [PW-1:0] poll_cnt, poll_cnt_inc;

  assign poll_cnt_inc = poll_cnt + PW'(1);
  assign poll_expired = (poll_cnt_inc == PW'(POLL_TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                    poll_cnt <= '0;
    else if (pop)                                   poll_cnt <= '0;
    else if (state_q == REQ && reg_ready_i && !req_done) poll_cnt <= poll_cnt_inc;
  end
`else
  assign poll_expired = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pop)         state_d = (head.op == OP_ILL) ? RESP : REQ;
      REQ:  if (reg_ready_i) state_d = (req_done || poll_expired) ? RESP : GAP;
      GAP:  if (gap_cnt == '0) state_d = REQ;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Working command and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur        <= '0;
      rsp_data   <= '0;
      rsp_status <= ST_OK;
      gap_cnt    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (pop) begin
          cur        <= head;
          rsp_data   <= '0;
          rsp_status <= (head.op == OP_ILL) ? ST_ILL : ST_OK;
        end
        REQ: if (reg_ready_i) begin
          gap_cnt    <= GW'(POLL_GAP - 1);
          rsp_data   <= (is_write && !reg_error_i) ? '0 : reg_rdata_i;
          if (reg_error_i)   rsp_status <= ST_BUS_ERR;
          else if (req_done) rsp_status <= ST_OK;
          else               rsp_status <= poll_expired ? ST_TIMEOUT : ST_OK;
        end
        GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, so valid drops as soon as reset asserts.
  always_comb begin
    reg_valid_o  = (state_q == REQ);
    reg_write_o  = reg_valid_o & is_write;
    reg_addr_o   = reg_valid_o ? cur.addr : '0;
    reg_wdata_o  = reg_write_o ? cur.data : '0;
    reg_wstrb_o  = reg_write_o ? 4'hF : 4'h0;
    rsp_valid_o  = (state_q == RESP);
    rsp_data_o   = rsp_valid_o ? rsp_data : '0;
    rsp_status_o = rsp_valid_o ? rsp_status : ST_OK;
    busy_o       = ~empty | (state_q != IDLE);
  end

endmodule
